prime_scanner: RTL and testbench
================================

# prime_scanner

Parametrised prime scanner. On a start request it tests every candidate from 2 up to a latched limit, using sequential trial division instead of a fixed lookup table. It streams one result per candidate and keeps a running prime count. It replaces the fixed 11-bit lookup counter in the exercise datapath and supports any `WIDTH`, with an explicit start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default 11: bit width of the limit, candidate, checked-number and count paths (≥ 3).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `num_max` in `WIDTH`: inclusive upper limit; latched when `start` is accepted.
- `busy` out 1: high in INIT and TEST.
- `done` out 1: one-cycle pulse in DONE.
- `check_valid` out 1: one-cycle pulse per candidate decided.
- `prime` out 1: result for `number_checked`; meaningful only while `check_valid` is high.
- `number_checked` out `WIDTH`: candidate just decided; holds its value between pulses.
- `prime_count` out `WIDTH`: number of primes found so far in this scan.
- `abort` in 1: present only with `PRIME_SCANNER_ABORT_EN`.

## Operation
States and transitions:
- **IDLE** → INIT on `start`. The same edge latches `num_max` into `lim` and clears `prime_count` and `number_checked` to 0.
- **INIT** sets `cand`=2 and `div`=3.
  - If `lim` < 2: → DONE.
  - Otherwise: → TEST.
- **TEST** evaluates one divisor per cycle for the current `cand`. Decision rules, in priority order:
  - `cand`==2: prime.
  - `div*div` > `cand`: prime. Compute the product in 2·`WIDTH`+2 bits with no truncation.
  - `cand % div` == 0: composite.
  - Otherwise: `div` += 2, stay undecided.
- On a deciding TEST cycle, at the next edge:
  - `check_valid`=1, `number_checked`=`cand`, `prime`=result.
  - `prime_count` += 1 if prime.
  - `div`=3.
  - `next` = 3 if `cand`==2, else `cand`+2. Compute `next` in `WIDTH`+1 bits.
  - If `next` > `lim` or `next` ≥ 2^`WIDTH`: → DONE. Otherwise `cand`=`next` and stay in TEST.
- **DONE**: `done`=1 for one cycle, → IDLE. `prime_count` and `number_checked` hold until the next accepted `start`.

Other rules:
- Only 2 and odd candidates are tested, so even divisors are never needed.
- `start` is ignored outside IDLE.
- `num_max` changes after acceptance have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `check_valid`=0, `prime`=0, `number_checked`=0, `prime_count`=0. State is IDLE.
- `rst` overrides every other input in every state. A scan interrupted by reset produces no `done` and no `check_valid`.
- If `start` is accepted at edge E0:
  - `busy` is high from E0.
  - The first `check_valid` (for candidate 2) is high in the cycle after E0+2.
- Each odd candidate spends k TEST cycles, where k is the number of divisors evaluated including the deciding one. Examples: 3, 5, 7 and 9 take 1 cycle each; 25 takes 2.
- Consecutive `check_valid` pulses are separated by at least 0 idle cycles, so back-to-back pulses are legal.
- `done` is high in the cycle after the last `check_valid`. With no candidates (`lim` < 2), `done` is high in the cycle after INIT.
- `busy` and `done` are never high together.
- A new `start` is accepted no earlier than the IDLE cycle that follows DONE.

## Configuration
- `PRIME_SCANNER_ABORT_EN` defined:
  - Adds input `abort`.
  - `abort`=1 sampled in INIT or TEST forces → DONE at that edge. No `check_valid` is produced for the pending candidate, and `prime_count` holds.
  - `abort` is ignored in IDLE and DONE.
  - `rst` has priority over `abort`.
- `PRIME_SCANNER_ABORT_EN` undefined: no `abort` port; a scan always runs to completion.

## Test plan
- `WIDTH`=11, `num_max`=10 → `check_valid` for 2, 3, 5, 7, 9 with `prime`=1, 1, 1, 1, 0; `done` with `prime_count`=4.
- `num_max`=1 and `num_max`=0 → no `check_valid`; `done` two cycles after the start edge; `prime_count`=0.
- `num_max`=25 → last check is 25 with `prime`=0 after 2 TEST cycles; `prime_count`=9; 2 is reported first and counted.
- `num_max`=2047 (`WIDTH`=11) → terminates without wrap; last `number_checked`=2047 with `prime`=0; `prime_count`=309.
- Assert `rst` for 1 cycle mid-scan (`num_max`=100, after the 5th `check_valid`) → all outputs 0 next cycle, IDLE. Then `start` with `num_max`=100 → `prime_count`=25.
- With `PRIME_SCANNER_ABORT_EN`: `abort` after the `check_valid` for 7 → `done` next cycle with `prime_count`=4; `start` pulsed while `busy` is ignored.

Source files
------------

// File: rtl/prime_scanner.sv
`default_nettype none
// ============================================================================
// Module      : prime_scanner
// Description : Scans every candidate from 2 up to a latched limit and
//               reports, one pulse per candidate, whether it is prime.
//               Primality is decided by sequential trial division with odd
//               divisors (one divisor per clock), and a running prime count
//               is kept for the scan.
// Revision    : 1.0 - initial release
//
// Optional feature macro:
//   PRIME_SCANNER_ABORT_EN - adds input 'abort'. When it is sampled high in
//                            INIT or TEST the scan jumps straight to DONE.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   scan request, only sampled in IDLE
//   num_max        in   inclusive upper limit, latched when start is taken
//   abort          in   (PRIME_SCANNER_ABORT_EN only) terminate the scan
//   busy           out  high while in INIT or TEST
//   done           out  one-cycle pulse in DONE
//   check_valid    out  one-cycle pulse per decided candidate
//   prime          out  result for number_checked (valid with check_valid)
//   number_checked out  candidate just decided, holds between pulses
//   prime_count    out  primes found so far in this scan
// ============================================================================
module prime_scanner #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_max,
`ifdef PRIME_SCANNER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             check_valid,
    output logic             prime,
    output logic [WIDTH-1:0] number_checked,
    output logic [WIDTH-1:0] prime_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_INIT = 2'd1;
    localparam logic [1:0] c_TEST = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int c_PW = 2 * WIDTH + 2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [WIDTH-1:0] r_lim;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_div;
    // Set when the last candidate has been decided: TEST spends one more
    // cycle so that done appears in the cycle after the final check_valid.
    logic             r_fin;
    logic             r_cv;
    logic             r_prime;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_count;

    logic             w_abort;
    logic [c_PW-1:0]  w_sq;
    logic [c_PW-1:0]  w_cand_ext;
    logic [WIDTH-1:0] w_rem;
    logic             w_is2;
    logic             w_sq_gt;
    logic             w_comp;
    logic             w_decide;
    logic             w_result;
    logic [WIDTH:0]   w_next;
    logic             w_last;

`ifdef PRIME_SCANNER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Divisor square is formed at full width so it can never wrap.
    assign w_sq       = {{(WIDTH + 2){1'b0}}, r_div} * {{(WIDTH + 2){1'b0}}, r_div};
    assign w_cand_ext = {{(WIDTH + 2){1'b0}}, r_cand};
    assign w_rem      = r_cand % r_div;

    assign w_is2    = (r_cand == WIDTH'(2));
    assign w_sq_gt  = (w_sq > w_cand_ext);
    assign w_comp   = (w_rem == '0);
    assign w_decide = !r_fin && (w_is2 || w_sq_gt || w_comp);
    assign w_result = w_is2 || w_sq_gt;

    // Next candidate carries one extra bit so the end of the number space
    // is detected instead of wrapping back to a small value.
    assign w_next = w_is2 ? (WIDTH + 1)'(3) : ({1'b0, r_cand} + (WIDTH + 1)'(2));
    assign w_last = (w_next > {1'b0, r_lim}) || w_next[WIDTH];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_INIT;
                end
            end
            c_INIT: begin
                if (w_abort || (r_lim < WIDTH'(2))) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_state_nxt = c_TEST;
                end
            end
            c_TEST: begin
                if (w_abort || r_fin) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_INIT:  busy = 1'b1;
            c_TEST:  busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lim   <= '0;
            r_cand  <= '0;
            r_div   <= '0;
            r_fin   <= 1'b0;
            r_cv    <= 1'b0;
            r_prime <= 1'b0;
            r_num   <= '0;
            r_count <= '0;
        end else begin
            r_cv    <= 1'b0;
            r_prime <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_lim   <= num_max;
                        r_count <= '0;
                        r_num   <= '0;
                        r_fin   <= 1'b0;
                    end
                end
                c_INIT: begin
                    r_cand <= WIDTH'(2);
                    r_div  <= WIDTH'(3);
                    r_fin  <= 1'b0;
                end
                c_TEST: begin
                    if (!w_abort) begin
                        if (w_decide) begin
                            r_cv    <= 1'b1;
                            r_num   <= r_cand;
                            r_prime <= w_result;
                            if (w_result) begin
                                r_count <= r_count + WIDTH'(1);
                            end
                            r_div <= WIDTH'(3);
                            if (w_last) begin
                                r_fin <= 1'b1;
                            end else begin
                                r_cand <= w_next[WIDTH-1:0];
                            end
                        end else if (!r_fin) begin
                            r_div <= r_div + WIDTH'(2);
                        end
                    end
                end
                default: begin
                    r_fin <= 1'b0;
                end
            endcase
        end
    end

    assign check_valid    = r_cv;
    assign prime          = r_prime;
    assign number_checked = r_num;
    assign prime_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_prime_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_scanner
// Description : Self-checking bench for prime_scanner (WIDTH = 11). A table
//               of limits with hand-computed results drives full scans; a
//               few hand-written sequences cover timing, reset, ignored
//               start and (when enabled) abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_scanner;

    localparam int W = 11;
    localparam int c_BUDGET = 60000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] num_max;
`ifdef PRIME_SCANNER_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         done;
    logic         check_valid;
    logic         prime;
    logic [W-1:0] number_checked;
    logic [W-1:0] prime_count;

    int n_err;
    int n_chk;

    prime_scanner #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_max        (num_max),
`ifdef PRIME_SCANNER_ABORT_EN
        .abort          (abort),
`endif
        .busy           (busy),
        .done           (done),
        .check_valid    (check_valid),
        .prime          (prime),
        .number_checked (number_checked),
        .prime_count    (prime_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lim;
        int checks;
        int last;
        int last_prime;
        int count;
    } vec_t;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one scan. Sample index 0 is the cycle right after the start edge.
    // abort_after >= 0 raises abort once that candidate has been reported;
    // inject != 0 pulses start (with another limit) while the scan is busy.
    task automatic run_scan(input int lim, input int abort_after, input int inject,
                            output int n_cv, output int last_num, output int last_pr,
                            output int cnt, output int first_idx, output int last_idx,
                            output int gap, output int done_idx, output int overlap);
        int prev_idx;
        bit fin;
        n_cv = 0; last_num = -1; last_pr = -1; cnt = -1;
        first_idx = -1; last_idx = -1; prev_idx = -1; gap = -1;
        done_idx = -1; overlap = 0; fin = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        num_max = W'(lim);
        @(negedge clk);
        start   = 1'b0;
        num_max = ~W'(lim);
        for (int idx = 0; idx < c_BUDGET && !fin; idx++) begin
            if (inject != 0 && idx == 3) begin
                start   = 1'b1;
                num_max = W'(100);
            end else if (inject != 0 && idx == 4) begin
                start = 1'b0;
            end
            if (busy && done) overlap++;
            if (check_valid) begin
                n_cv++;
                chk($sformatf("prime_of_%0d", number_checked), int'(prime),
                    int'(is_prime(int'(number_checked))));
                if (first_idx < 0) first_idx = idx;
                prev_idx = last_idx;
                last_idx = idx;
                last_num = int'(number_checked);
                last_pr  = int'(prime);
`ifdef PRIME_SCANNER_ABORT_EN
                if (abort_after >= 0 && int'(number_checked) == abort_after) abort = 1'b1;
`endif
            end
            if (done) begin
                done_idx = idx;
                cnt = int'(prime_count);
                fin = 1'b1;
`ifdef PRIME_SCANNER_ABORT_EN
                abort = 1'b0;
`endif
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (prev_idx >= 0) gap = last_idx - prev_idx;
        if (!fin) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout lim=%0d: no done within %0d cycles", lim, c_BUDGET);
        end
        if (abort_after < 0) begin
        end
    endtask

    vec_t vecs[9];

    initial begin
        int n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov;
        int cv_seen;

        n_err = 0;
        n_chk = 0;
        // limit, checks, last checked, last prime flag, prime count
        vecs[0] = '{10,   5,    9,    0, 4};
        vecs[1] = '{1,    0,    0,    0, 0};
        vecs[2] = '{0,    0,    0,    0, 0};
        vecs[3] = '{2,    1,    2,    1, 1};
        vecs[4] = '{3,    2,    3,    1, 2};
        vecs[5] = '{13,   7,    13,   1, 6};
        vecs[6] = '{25,   13,   25,   0, 9};
        vecs[7] = '{100,  50,   99,   0, 25};
        vecs[8] = '{2047, 1024, 2047, 0, 309};

        rst     = 1'b1;
        start   = 1'b0;
        num_max = '0;
`ifdef PRIME_SCANNER_ABORT_EN
        abort   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   int'(busy), 0);
        chk("reset_done",   int'(done), 0);
        chk("reset_cv",     int'(check_valid), 0);
        chk("reset_prime",  int'(prime), 0);
        chk("reset_num",    int'(number_checked), 0);
        chk("reset_count",  int'(prime_count), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_scan(vecs[i].lim, -1, 0, n_cv, last_num, last_pr, cnt,
                     first_idx, last_idx, gap, done_idx, ov);
            chk($sformatf("count_lim%0d", vecs[i].lim), cnt, vecs[i].count);
            chk($sformatf("ncheck_lim%0d", vecs[i].lim), n_cv, vecs[i].checks);
            chk($sformatf("overlap_lim%0d", vecs[i].lim), ov, 0);
            if (vecs[i].checks > 0) begin
                chk($sformatf("last_lim%0d", vecs[i].lim), last_num, vecs[i].last);
                chk($sformatf("lastpr_lim%0d", vecs[i].lim), last_pr, vecs[i].last_prime);
                chk($sformatf("first_idx_lim%0d", vecs[i].lim), first_idx, 2);
                chk($sformatf("done_idx_lim%0d", vecs[i].lim), done_idx, last_idx + 1);
            end else begin
                chk($sformatf("done_idx_lim%0d", vecs[i].lim), done_idx, 1);
                chk($sformatf("numchk_lim%0d", vecs[i].lim), int'(number_checked), 0);
            end
            // After DONE, outputs hold and the scanner sits idle.
            @(negedge clk);
            chk($sformatf("hold_count_lim%0d", vecs[i].lim), int'(prime_count), vecs[i].count);
            chk($sformatf("idle_busy_lim%0d", vecs[i].lim), int'(busy), 0);
        end

        // 3,5,7,9 each decided in one cycle: 9 follows 7 back to back.
        run_scan(10, -1, 0, n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov);
        chk("gap_7_to_9", gap, 1);
        chk("idx_of_9", last_idx, 6);
        // 23 and 25 each need two divisors.
        run_scan(25, -1, 0, n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov);
        chk("gap_23_to_25", gap, 2);

        // start while busy is ignored: result is that of the original limit.
        run_scan(10, -1, 1, n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov);
        chk("ignored_start_count", cnt, 4);
        chk("ignored_start_checks", n_cv, 5);

        // Reset mid-scan after the fifth result.
        @(negedge clk);
        start   = 1'b1;
        num_max = W'(100);
        @(negedge clk);
        start   = 1'b0;
        cv_seen = 0;
        for (int k = 0; k < 200 && cv_seen < 5; k++) begin
            if (check_valid) cv_seen++;
            if (cv_seen < 5) @(negedge clk);
        end
        chk("mid_reset_cv_seen", cv_seen, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_busy",  int'(busy), 0);
        chk("mid_reset_done",  int'(done), 0);
        chk("mid_reset_cv",    int'(check_valid), 0);
        chk("mid_reset_num",   int'(number_checked), 0);
        chk("mid_reset_count", int'(prime_count), 0);
        repeat (3) begin
            @(negedge clk);
            chk("after_reset_quiet", int'(done | check_valid | busy), 0);
        end
        run_scan(100, -1, 0, n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov);
        chk("after_reset_count", cnt, 25);

`ifdef PRIME_SCANNER_ABORT_EN
        run_scan(100, 7, 0, n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov);
        chk("abort_count", cnt, 4);
        chk("abort_checks", n_cv, 4);
        chk("abort_last", last_num, 7);
        chk("abort_done_idx", done_idx, last_idx + 1);
        run_scan(10, -1, 0, n_cv, last_num, last_pr, cnt, first_idx, last_idx, gap, done_idx, ov);
        chk("post_abort_count", cnt, 4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
